bht_write_scheduler: RTL and testbench
======================================

Name: bht_write_scheduler

Overview:
Sequences every write into the 64-entry, 4-way branch history table through its single write port. It arbitrates between three sources: ID-stage allocations, EXE-stage saturating-counter updates, and a whole-table invalidate sweep. It owns the per-set FIFO replacement pointers and holds a small queue for counter updates that lose arbitration. It sits between the predictor's ID/EXE decision logic and the history_table storage array.

Parameters:
SETS, 16, number of sets (index = {set, way})
WAYS, 4, ways per set (FIFO pointer width = log2(WAYS))
TAG_W, 6, tag field width
TGT_W, 10, branch target field width
QDEPTH, 2, pending counter-update queue depth

Ports:
CLK  in  1  clock
nrst  in  1  asynchronous active-low reset
alloc_valid  in  1  ID stage requests a new entry (branch/jump miss)
alloc_set  in  4  set of new entry
alloc_tag  in  6  tag of new entry
alloc_target  in  10  branch target of new entry
alloc_is_jump  in  1  1: init counter 2'b11, 0: init 2'b01
upd_valid  in  1  EXE resolved a branch that hit in the table
upd_idx  in  6  {set, way} of the hit entry
upd_entry  in  19  current 19-bit entry contents {valid, tag, target, ctr}
upd_taken  in  1  resolved outcome (1 = increment, 0 = decrement)
inv_req  in  1  start full-table invalidate sweep
wr_en  out  1  table write strobe
wr_idx  out  6  table write index
wr_data  out  19  table write data
alloc_way  out  2  way chosen for the accepted allocation (registered with wr_*)
upd_drop  out  1  one-cycle pulse: an update was discarded
busy  out  1  sweep in progress

Behaviour:
- Reset (async, nrst=0): wr_en=0, wr_idx=0, wr_data=0, alloc_way=0, upd_drop=0, busy=0. All 16 FIFO pointers = 0. Queue empty. State = IDLE.
- wr_* and alloc_way are registered. The winner chosen in cycle N drives wr_* in cycle N+1. At most one write per cycle.
- Priority: sweep > alloc > queue head > incoming update.
- Alloc: writes {1, tag, target, init_ctr} to idx {set, ptr[set]}. ptr[set] increments mod 4, wrapping 3 to 0. alloc_way = the pre-increment ptr value.
- Update: new counter = ctr+1 if upd_taken, else ctr-1, saturating at 3/0. No write and no enqueue when already saturated in the requested direction. Data = upd_entry with ctr[1:0] replaced.
- Update is written directly only if the queue is empty and no alloc wins that cycle. Otherwise it is enqueued in FIFO order.
- Enqueue while the queue is full: the update is lost and upd_drop=1 in the next cycle.
- Stale kill: when an alloc wins with idx X, every queued entry with idx X is removed. A same-cycle incoming update with idx X is discarded without upd_drop.
- FSM IDLE/SWEEP:
  - inv_req in IDLE → SWEEP next cycle with busy=1.
  - SWEEP writes 19'b0 to idx 0..63, one per cycle, over 64 cycles.
  - SWEEP clears all pointers and the queue on entry.
  - Returns to IDLE after idx 63; busy falls the cycle after the final write.
  - inv_req during SWEEP is ignored.
  - alloc_valid during SWEEP is ignored.
  - upd_valid during SWEEP is discarded with upd_drop=1.
- Reset mid-sweep aborts immediately to the reset state; partially swept entries are not restored.
- Queue entries store idx and the computed 19-bit data, not a recomputation at drain time.

Decomposition:
- Package bp_pkg:
  - Entry field positions: VALID=18, TAG=17:12, TGT=11:2, CTR=1:0.
  - Widths TAG_W, TGT_W, IDX_W=6.
  - Counter init constants CTR_JUMP_INIT=2'b11 and CTR_BR_INIT=2'b01.
  - FSM state enum {IDLE, SWEEP}.
- Sub-module bht_upd_queue: a QDEPTH-entry FIFO of {idx, data} with an index-match kill port.
- Saturating arithmetic and arbitration stay in the top module.

Test Plan:
- Four allocs to set 5 then a fifth → wr_idx 0x14, 0x15, 0x16, 0x17, then 0x14 again; alloc_way 0, 1, 2, 3, 0; ctr=2'b01 for branches, 2'b11 for jumps.
- upd_valid with idx 0x21, ctr=2'b11, taken=1 → no write. With ctr=2'b01, taken=0 → wr_data ctr=2'b00 one cycle later.
- Alloc and update in the same cycle on different idx → alloc written cycle N+1, update written cycle N+2 from the queue.
- Alloc held every cycle with 3 updates → 2 updates queued; the third gives upd_drop=1. Updates drain in order once alloc stops.
- Queued update for idx 0x08, then alloc to set 2 with ptr=0 (idx 0x08) → queued update removed, never written, upd_drop stays 0.
- inv_req → busy=1 for 64 cycles, wr_idx 0..63 with data 0. An alloc mid-sweep is ignored. After the sweep, an alloc to set 0 lands at way 0. nrst pulsed mid-sweep → busy=0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// bp_pkg - BHT entry layout, widths, counter init values and scheduler states
// Rev 1.0
// ============================================================================
package bp_pkg;

  localparam int TAG_W   = 6;
  localparam int TGT_W   = 10;
  localparam int IDX_W   = 6;
  localparam int ENTRY_W = 1 + TAG_W + TGT_W + 2;

  localparam int VALID_BIT = 18;
  localparam int TAG_MSB   = 17;
  localparam int TAG_LSB   = 12;
  localparam int TGT_MSB   = 11;
  localparam int TGT_LSB   = 2;
  localparam int CTR_MSB   = 1;
  localparam int CTR_LSB   = 0;

  localparam logic [1:0] CTR_JUMP_INIT = 2'b11;
  localparam logic [1:0] CTR_BR_INIT   = 2'b01;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(
    input logic [TAG_W-1:0] tag,
    input logic [TGT_W-1:0] tgt,
    input logic [1:0]       ctr
  );
    logic [ENTRY_W-1:0] e;
    e                  = '0;
    e[VALID_BIT]       = 1'b1;
    e[TAG_MSB:TAG_LSB] = tag;
    e[TGT_MSB:TGT_LSB] = tgt;
    e[CTR_MSB:CTR_LSB] = ctr;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_upd_queue.sv
`default_nettype none
// ============================================================================
// bht_upd_queue - small compacting FIFO of deferred {idx, data} counter writes
// Rev 1.0
// ============================================================================
module bht_upd_queue #(
  parameter int QDEPTH = 2,
  parameter int IDX_W  = 6,
  parameter int DATA_W = 19
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              clear,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [IDX_W-1:0]  kill_idx,
  output logic              head_valid,
  output logic [IDX_W-1:0]  head_idx,
  output logic [DATA_W-1:0] head_data,
  output logic              push_drop
);

  logic [QDEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  idx_q  [QDEPTH];
  logic [IDX_W-1:0]  idx_d  [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [DATA_W-1:0] data_d [QDEPTH];

  // Survivors of pop/kill are packed toward slot 0 so order is preserved,
  // then the new entry lands in the first free slot.
  always_comb begin
    int kc;
    vld_d     = '0;
    push_drop = 1'b0;
    kc        = 0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx_d[i]  = '0;
      data_d[i] = '0;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld_q[i] && !(kill_en && (idx_q[i] == kill_idx)) && !(pop && (i == 0))) begin
        vld_d[kc]  = 1'b1;
        idx_d[kc]  = idx_q[i];
        data_d[kc] = data_q[i];
        kc         = kc + 1;
      end
    end
    if (push) begin
      if (kc < QDEPTH) begin
        vld_d[kc]  = 1'b1;
        idx_d[kc]  = push_idx;
        data_d[kc] = push_data;
      end else begin
        push_drop = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      vld_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      data_q <= data_d;
    end
  end

  assign head_valid = vld_q[0];
  assign head_idx   = idx_q[0];
  assign head_data  = data_q[0];

endmodule
`default_nettype wire

// File: rtl/bht_write_scheduler.sv
`default_nettype none
// ============================================================================
// bht_write_scheduler - arbitrates sweep/alloc/update writes onto the BHT port
// Rev 1.0
// ============================================================================
module bht_write_scheduler #(
  parameter  int SETS    = 16,
  parameter  int WAYS    = 4,
  parameter  int TAG_W   = 6,
  parameter  int TGT_W   = 10,
  parameter  int QDEPTH  = 2,
  localparam int SET_W   = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS),
  localparam int IDX_W   = SET_W + WAY_W,
  localparam int ENTRY_W = 1 + TAG_W + TGT_W + 2
) (
  input  logic               CLK,
  input  logic               nrst,
  input  logic               alloc_valid,
  input  logic [SET_W-1:0]   alloc_set,
  input  logic [TAG_W-1:0]   alloc_tag,
  input  logic [TGT_W-1:0]   alloc_target,
  input  logic               alloc_is_jump,
  input  logic               upd_valid,
  input  logic [IDX_W-1:0]   upd_idx,
  input  logic [ENTRY_W-1:0] upd_entry,
  input  logic               upd_taken,
  input  logic               inv_req,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_idx,
  output logic [ENTRY_W-1:0] wr_data,
  output logic [WAY_W-1:0]   alloc_way,
  output logic               upd_drop,
  output logic               busy
);
  import bp_pkg::*;

  state_t             state, next_state;
  logic [IDX_W-1:0]   sweep_cnt;
  logic [WAY_W-1:0]   ptr [SETS];

  logic               sweep_start, sweep_win, alloc_win, head_win;
  logic               upd_live, upd_kill, upd_direct, upd_push, drop_next;
  logic [1:0]         cur_ctr, new_ctr;
  logic [IDX_W-1:0]   alloc_idx, q_head_idx;
  logic [ENTRY_W-1:0] alloc_data, upd_data, q_head_data;
  logic               q_head_valid, q_push_drop;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (inv_req) next_state = SWEEP;
      SWEEP:   if (sweep_cnt == '1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cur_ctr  = upd_entry[CTR_MSB:CTR_LSB];
    if (upd_taken) begin
      upd_live = upd_valid && (cur_ctr != 2'b11);
      new_ctr  = cur_ctr + 2'b01;
    end else begin
      upd_live = upd_valid && (cur_ctr != 2'b00);
      new_ctr  = cur_ctr - 2'b01;
    end
    upd_data                   = upd_entry;
    upd_data[CTR_MSB:CTR_LSB]  = new_ctr;

    // The first sweep write is issued in the same cycle inv_req is seen.
    sweep_start = (state == IDLE) && inv_req;
    sweep_win   = (state == SWEEP) || sweep_start;
    alloc_win   = !sweep_win && alloc_valid;
    alloc_idx   = {alloc_set, ptr[alloc_set]};
    alloc_data  = make_entry(alloc_tag, alloc_target,
                             alloc_is_jump ? CTR_JUMP_INIT : CTR_BR_INIT);
    head_win    = !sweep_win && !alloc_win && q_head_valid;
    upd_kill    = alloc_win && (upd_idx == alloc_idx);
    upd_direct  = !sweep_win && !alloc_valid && !q_head_valid && upd_live;
    upd_push    = !sweep_win && upd_live && !upd_kill && !upd_direct;
  end

  assign drop_next = (sweep_win && upd_valid) || q_push_drop;

  bht_upd_queue #(
    .QDEPTH (QDEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (ENTRY_W)
  ) u_queue (
    .CLK        (CLK),
    .nrst       (nrst),
    .clear      (sweep_win),
    .push       (upd_push),
    .push_idx   (upd_idx),
    .push_data  (upd_data),
    .pop        (head_win),
    .kill_en    (alloc_win),
    .kill_idx   (alloc_idx),
    .head_valid (q_head_valid),
    .head_idx   (q_head_idx),
    .head_data  (q_head_data),
    .push_drop  (q_push_drop)
  );

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else if (sweep_start) begin
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else if (alloc_win) begin
      ptr[alloc_set] <= ptr[alloc_set] + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      wr_en     <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      alloc_way <= '0;
      upd_drop  <= 1'b0;
      busy      <= 1'b0;
      sweep_cnt <= '0;
    end else begin
      wr_en    <= sweep_win | alloc_win | head_win | upd_direct;
      upd_drop <= drop_next;
      busy     <= sweep_win;
      if (sweep_win) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        wr_idx    <= sweep_cnt;
        wr_data   <= '0;
      end else if (alloc_win) begin
        wr_idx    <= alloc_idx;
        wr_data   <= alloc_data;
        alloc_way <= ptr[alloc_set];
      end else if (head_win) begin
        wr_idx    <= q_head_idx;
        wr_data   <= q_head_data;
      end else if (upd_direct) begin
        wr_idx    <= upd_idx;
        wr_data   <= upd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bht_write_scheduler.sv
`default_nettype none
// tb_bht_write_scheduler: directed and randomized checks of the BHT write
// scheduler against a queue-based behavioural model.
module tb_bht_write_scheduler;

  localparam int QD = 2;

  logic        CLK = 1'b0;
  logic        nrst;
  logic        alloc_valid;
  logic [3:0]  alloc_set;
  logic [5:0]  alloc_tag;
  logic [9:0]  alloc_target;
  logic        alloc_is_jump;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic [18:0] upd_entry;
  logic        upd_taken;
  logic        inv_req;
  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [18:0] wr_data;
  logic [1:0]  alloc_way;
  logic        upd_drop;
  logic        busy;

  always #5 CLK = ~CLK;

  bht_write_scheduler dut (
    .CLK(CLK), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_set(alloc_set), .alloc_tag(alloc_tag),
    .alloc_target(alloc_target), .alloc_is_jump(alloc_is_jump),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_entry(upd_entry),
    .upd_taken(upd_taken), .inv_req(inv_req),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_way(alloc_way),
    .upd_drop(upd_drop), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [18:0] data;
  } qe_t;

  int          m_ptr [16];
  qe_t         m_q [$];
  int          m_sweep;
  logic        exp_wr_en, exp_drop, exp_busy, exp_alloc;
  logic [5:0]  exp_idx;
  logic [18:0] exp_data;
  logic [1:0]  exp_way;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) m_ptr[s] = 0;
    m_q.delete();
    m_sweep   = -1;
    exp_wr_en = 0; exp_drop = 0; exp_busy = 0; exp_alloc = 0;
    exp_idx   = '0; exp_data = '0; exp_way = '0;
  endtask

  task automatic m_enqueue(input int idx, input logic [18:0] data);
    qe_t e;
    if (m_q.size() < QD) begin
      e.idx  = idx;
      e.data = data;
      m_q.push_back(e);
    end else begin
      exp_drop = 1;
    end
  endtask

  // Expected registered outputs for the edge that consumes the current inputs.
  task automatic model_step();
    int          c, nc, widx;
    logic        live;
    logic [18:0] udata;
    exp_wr_en = 0; exp_drop = 0; exp_alloc = 0;
    c     = int'(upd_entry) % 4;
    nc    = upd_taken ? c + 1 : c - 1;
    live  = upd_valid && (nc >= 0) && (nc <= 3);
    udata = 19'((int'(upd_entry) / 4) * 4 + nc);
    if (m_sweep < 0 && inv_req) begin
      m_sweep = 0;
      for (int s = 0; s < 16; s++) m_ptr[s] = 0;
      m_q.delete();
    end
    if (m_sweep >= 0) begin
      exp_wr_en = 1;
      exp_idx   = 6'(m_sweep);
      exp_data  = '0;
      exp_drop  = upd_valid;
      exp_busy  = 1;
      m_sweep++;
      if (m_sweep == 64) m_sweep = -1;
    end else begin
      exp_busy = 0;
      if (alloc_valid) begin
        widx      = int'(alloc_set) * 4 + m_ptr[alloc_set];
        exp_wr_en = 1;
        exp_alloc = 1;
        exp_idx   = 6'(widx);
        exp_data  = 19'((1 << 18) + int'(alloc_tag) * 4096 + int'(alloc_target) * 4
                        + (alloc_is_jump ? 3 : 1));
        exp_way   = 2'(m_ptr[alloc_set]);
        m_ptr[alloc_set] = (m_ptr[alloc_set] + 1) % 4;
        for (int i = m_q.size() - 1; i >= 0; i--)
          if (m_q[i].idx == widx) m_q.delete(i);
        if (live && int'(upd_idx) != widx) m_enqueue(int'(upd_idx), udata);
      end else if (m_q.size() > 0) begin
        exp_wr_en = 1;
        exp_idx   = 6'(m_q[0].idx);
        exp_data  = m_q[0].data;
        m_q.pop_front();
        if (live) m_enqueue(int'(upd_idx), udata);
      end else if (live) begin
        exp_wr_en = 1;
        exp_idx   = upd_idx;
        exp_data  = udata;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
    check("wr_en", wr_en, exp_wr_en);
    check("busy", busy, exp_busy);
    check("upd_drop", upd_drop, exp_drop);
    if (exp_wr_en) begin
      check("wr_idx", wr_idx, exp_idx);
      check("wr_data", wr_data, exp_data);
    end
    if (exp_alloc) check("alloc_way", alloc_way, exp_way);
    @(negedge CLK);
  endtask

  task automatic set_idle();
    alloc_valid = 0; alloc_set = '0; alloc_tag = '0; alloc_target = '0; alloc_is_jump = 0;
    upd_valid = 0; upd_idx = '0; upd_entry = '0; upd_taken = 0; inv_req = 0;
  endtask

  initial begin
    logic [18:0] d;
    logic        heavy;
    nrst = 0;
    set_idle();
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_alloc_way", alloc_way, 0);
    check("rst_upd_drop", upd_drop, 0);
    check("rst_busy", busy, 0);
    nrst = 1;
    @(negedge CLK);

    // Five allocations into set 5: ways 0,1,2,3 then wrap to 0.
    for (int k = 0; k < 5; k++) begin
      set_idle();
      alloc_valid = 1; alloc_set = 4'd5; alloc_tag = 6'(k + 1);
      alloc_target = 10'(k * 3); alloc_is_jump = k[0];
      cycle();
      d = {1'b1, 6'(k + 1), 10'(k * 3), (k % 2 == 1) ? 2'b11 : 2'b01};
      check("alloc5_idx", wr_idx, 32'h14 + 32'(k % 4));
      check("alloc5_way", alloc_way, 32'(k % 4));
      check("alloc5_data", wr_data, d);
    end

    // Saturated increment writes nothing; decrement of 01 writes 00.
    set_idle();
    upd_valid = 1; upd_idx = 6'h21; upd_entry = {1'b1, 6'h2a, 10'h155, 2'b11}; upd_taken = 1;
    cycle();
    check("sat_no_write", wr_en, 0);
    upd_entry = {1'b1, 6'h2a, 10'h155, 2'b01}; upd_taken = 0;
    cycle();
    check("dec_idx", wr_idx, 6'h21);
    check("dec_data", wr_data, {1'b1, 6'h2a, 10'h155, 2'b00});

    // Alloc and update together: alloc first, update one cycle later from the queue.
    set_idle();
    alloc_valid = 1; alloc_set = 4'd3;
    upd_valid = 1; upd_idx = 6'h30; upd_entry = {1'b1, 6'h01, 10'h002, 2'b01}; upd_taken = 1;
    cycle();
    check("same_alloc_idx", wr_idx, 6'h0c);
    set_idle();
    cycle();
    check("same_upd_idx", wr_idx, 6'h30);
    check("same_upd_data", wr_data, {1'b1, 6'h01, 10'h002, 2'b10});

    // Alloc held for three cycles with three updates: third overflows.
    for (int k = 1; k <= 3; k++) begin
      set_idle();
      alloc_valid = 1; alloc_set = 4'd7;
      upd_valid = 1; upd_idx = 6'(k); upd_entry = {1'b1, 6'(k), 10'(k), 2'b00}; upd_taken = 1;
      cycle();
      check("hold_drop", upd_drop, (k == 3) ? 1 : 0);
    end
    set_idle();
    cycle();
    check("drain1_idx", wr_idx, 6'h01);
    check("drain1_data", wr_data, {1'b1, 6'h01, 10'h001, 2'b01});
    cycle();
    check("drain2_idx", wr_idx, 6'h02);
    cycle();
    check("drain_done", wr_en, 0);

    // Stale kill: queued update to 0x08 is overwritten by an alloc to 0x08.
    set_idle();
    alloc_valid = 1; alloc_set = 4'd9;
    upd_valid = 1; upd_idx = 6'h08; upd_entry = {1'b1, 6'h11, 10'h022, 2'b01}; upd_taken = 1;
    cycle();
    set_idle();
    alloc_valid = 1; alloc_set = 4'd2;
    cycle();
    check("kill_alloc_idx", wr_idx, 6'h08);
    check("kill_no_drop", upd_drop, 0);
    set_idle();
    cycle();
    check("kill_gone1", wr_en, 0);
    cycle();
    check("kill_gone2", wr_en, 0);

    // Full sweep with an alloc and a second inv_req mid-way, both ignored.
    set_idle();
    inv_req = 1;
    cycle();
    check("sweep_idx0", wr_idx, 0);
    check("sweep_busy0", busy, 1);
    for (int i = 1; i < 64; i++) begin
      set_idle();
      if (i == 10) begin alloc_valid = 1; alloc_set = 4'd0; end
      if (i == 20) inv_req = 1;
      cycle();
      check("sweep_idx", wr_idx, 32'(i));
      check("sweep_data", wr_data, 0);
      check("sweep_busy", busy, 1);
    end
    set_idle();
    cycle();
    check("sweep_busy_fall", busy, 0);
    alloc_valid = 1; alloc_set = 4'd5;
    cycle();
    check("post_sweep_idx", wr_idx, 6'h14);
    check("post_sweep_way", alloc_way, 0);

    // Randomized traffic.
    heavy = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) heavy = ~heavy;
      alloc_valid   = ($urandom_range(0, 99) < (heavy ? 80 : 30));
      alloc_set     = 4'($urandom);
      alloc_tag     = 6'($urandom);
      alloc_target  = 10'($urandom);
      alloc_is_jump = 1'($urandom);
      upd_valid     = ($urandom_range(0, 99) < 60);
      upd_idx       = ($urandom_range(0, 99) < 30) ? 6'(int'(alloc_set) * 4 + m_ptr[alloc_set])
                                                   : 6'($urandom);
      upd_entry     = 19'($urandom);
      upd_taken     = 1'($urandom);
      inv_req       = ($urandom_range(0, 399) == 0);
      cycle();
    end

    set_idle();
    for (int n = 0; n < 70; n++) cycle();

    // Reset in the middle of a sweep.
    inv_req = 1;
    cycle();
    set_idle();
    for (int n = 0; n < 12; n++) cycle();
    nrst = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_idx", wr_idx, 0);
    model_reset();
    @(negedge CLK);
    nrst = 1;
    @(negedge CLK);
    alloc_valid = 1; alloc_set = 4'd0;
    cycle();
    check("after_rst_idx", wr_idx, 0);
    check("after_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
